// File: rtl/button_pattern_gen_if.sv
// Bus bundle for the serial pattern generator: request side (en/start/stop/pattern/len)
// driven by the master, serial line and status (y/busy/done) driven by the generator.
// No handshake beyond start/done; the master must respect busy.
interface button_pattern_gen_if #(
  parameter int WIDTH = 8,
  parameter int LEN_W = $clog2(WIDTH + 1)
);
  logic             en;
  logic             start;
  logic             stop;
  logic [WIDTH-1:0] pattern;
  logic [LEN_W-1:0] len;
  logic             y;
  logic             busy;
  logic             done;

  modport master (
    output en, start, stop, pattern, len,
    input  y, busy, done
  );

  modport slave (
    input  en, start, stop, pattern, len,
    output y, busy, done
  );
endinterface

// File: rtl/button_pattern_gen.sv
// Serial bit-pattern generator: sends len bits of pattern MSB-first on y, one per en, then GAP low periods, then done.
// Latency: first bit on y two cycles after start with en tied high; done at len+GAP+2.
// Backpressure: start is only accepted in IDLE; requests while busy or in DONE are dropped, stop aborts.
module button_pattern_gen #(
  parameter int WIDTH = 8,
  parameter int GAP   = 2,
  parameter int LEN_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  button_pattern_gen_if.slave  bus
);

  localparam int IW = $clog2(WIDTH);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [GW-1:0]    GCNT_INIT = GW'(GAP);
  localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAPS = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] pattern_q;
  logic [IW-1:0]    idx;
  logic [GW-1:0]    gcnt;
  logic             y_q;
  logic [LEN_W-1:0] len_c;

  // Oversized lengths are clamped so idx can never point outside the pattern.
  always_comb begin
    len_c = bus.len;
    if (bus.len > LEN_MAX) begin
      len_c = LEN_MAX;
    end
  end

  // Frame sequencer: state, captured pattern, bit index, gap counter and the registered serial line.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pattern_q <= '0;
      idx       <= '0;
      gcnt      <= '0;
      y_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          y_q <= 1'b0;
          // stop in the same cycle as start drops the request
          if (bus.start && !bus.stop) begin
            pattern_q <= bus.pattern;
            if (len_c == '0) begin
              state <= DONE;
            end else begin
              idx   <= IW'(len_c - LEN_W'(1));
              state <= SEND;
            end
          end
        end
        SEND: begin
          if (bus.stop) begin
            y_q   <= 1'b0;
            state <= IDLE;
          end else if (bus.en) begin
            y_q <= pattern_q[idx];
            if (idx == '0) begin
              gcnt  <= GCNT_INIT;
              state <= GAPS;
            end else begin
              idx <= idx - 1'b1;
            end
          end
        end
        GAPS: begin
          if (bus.stop) begin
            y_q   <= 1'b0;
            state <= IDLE;
          end else if (bus.en) begin
            // the first tick here ends the last bit's period, so GAP+1 ticks give GAP low periods
            y_q <= 1'b0;
            if (gcnt == '0) begin
              state <= DONE;
            end else begin
              gcnt <= gcnt - 1'b1;
            end
          end
        end
        DONE: begin
          y_q   <= 1'b0;
          state <= IDLE;
        end
        default: begin
          y_q   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.y    = y_q;
  assign bus.busy = (state == SEND) || (state == GAPS);
  // done follows the DONE state, so it shows even if stop arrives that same cycle
  assign bus.done = (state == DONE);

endmodule

// File: tb/tb_button_pattern_gen.sv
// Directed bench for button_pattern_gen: per-cycle logs of y/busy/done compared against hand-derived vectors.
// Cycle 0 is the cycle carrying start; bit c of each log holds the output seen during cycle c.
// Inputs change 1 time unit after the rising edge and outputs are sampled at the same point.
module tb_button_pattern_gen;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_pass;

  logic [63:0] y_v;
  logic [63:0] busy_v;
  logic [63:0] done_v;

  button_pattern_gen_if #(.WIDTH(8)) bus_if ();

  button_pattern_gen #(
    .WIDTH(8),
    .GAP  (2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Runs ncyc cycles with start in cycle 0; pattern/len are scrambled after cycle 0.
  // busy_start, stop_cyc and rst_cyc select the cycle of an extra start, stop or reset (-1 = none).
  task automatic run_frame(input logic [7:0] pat, input logic [3:0] ln, input int period,
                           input int ncyc, input int busy_start, input int stop_cyc,
                           input int rst_cyc);
    y_v    = '0;
    busy_v = '0;
    done_v = '0;
    for (int c = 0; c < ncyc; c++) begin
      bus_if.en      = (period == 1) ? 1'b1 : ((c % period) == 1);
      bus_if.start   = (c == 0) || (c == busy_start);
      bus_if.pattern = (c == 0) ? pat : ~pat;
      bus_if.len     = (c == 0) ? ln : 4'd8;
      bus_if.stop    = (c == stop_cyc);
      reset          = (c == rst_cyc);
      y_v[c]         = bus_if.y;
      busy_v[c]      = bus_if.busy;
      done_v[c]      = bus_if.done;
      @(posedge clk);
      #1;
    end
    bus_if.en    = 1'b1;
    bus_if.start = 1'b0;
    bus_if.stop  = 1'b0;
    reset        = 1'b0;
  endtask

  task automatic check_basic(input string tag);
    check({tag, "_y"},    y_v,    64'h00C);
    check({tag, "_busy"}, busy_v, 64'h07E);
    check({tag, "_done"}, done_v, 64'h080);
  endtask

  initial begin
    logic [7:0] a5_bits;
    n_chk  = 0;
    n_pass = 0;
    a5_bits = 8'hA5;

    reset          = 1'b1;
    bus_if.en      = 1'b1;
    bus_if.start   = 1'b0;
    bus_if.stop    = 1'b0;
    bus_if.pattern = '0;
    bus_if.len     = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_y",    {63'd0, bus_if.y},    64'd0);
    check("rst_busy", {63'd0, bus_if.busy}, 64'd0);
    check("rst_done", {63'd0, bus_if.done}, 64'd0);

    // basic: 110 on y in cycles 2-4, busy 1-6, done 7
    run_frame(8'b0000_0110, 4'd3, 1, 10, -1, -1, -1);
    check_basic("basic");

    // slow strobe: en in cycles 1,5,9,...; bit k held in cycles 2+4k .. 5+4k
    run_frame(8'hA5, 4'd8, 4, 45, -1, -1, -1);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("slow_bit%0d_first", k), {63'd0, y_v[2+4*k]}, {63'd0, a5_bits[7-k]});
      check($sformatf("slow_bit%0d_last", k),  {63'd0, y_v[5+4*k]}, {63'd0, a5_bits[7-k]});
    end
    check("slow_gap_low", {56'd0, y_v[41:34]}, 64'd0);
    check("slow_busy",    busy_v, 64'h0000_03FF_FFFF_FFFE);
    check("slow_done",    done_v, 64'h0000_0400_0000_0000);

    // len 0: straight to DONE in cycle 1
    run_frame(8'hFF, 4'd0, 1, 4, -1, -1, -1);
    check("len0_y",    y_v,    64'h0);
    check("len0_busy", busy_v, 64'h0);
    check("len0_done", done_v, 64'h2);

    // len 12 clamps to 8: A5 on y in cycles 2-9, busy 1-11, done 12
    run_frame(8'hA5, 4'd12, 1, 14, -1, -1, -1);
    check("len12_y",    y_v,    64'h0294);
    check("len12_busy", busy_v, 64'h0FFE);
    check("len12_done", done_v, 64'h1000);

    // start pulsed in cycle 3 while busy: frame unchanged
    run_frame(8'b0000_0110, 4'd3, 1, 10, 3, -1, -1);
    check_basic("busy_start");

    // stop while y shows the second bit (cycle 3): IDLE from cycle 4, no done
    run_frame(8'b0000_0110, 4'd3, 1, 10, -1, 3, -1);
    check("abort_y",    y_v,    64'h00C);
    check("abort_busy", busy_v, 64'h00E);
    check("abort_done", done_v, 64'h000);
    run_frame(8'b0000_0110, 4'd3, 1, 10, -1, -1, -1);
    check_basic("after_abort");

    // start and stop together in IDLE: nothing happens
    run_frame(8'hFF, 4'd8, 1, 10, -1, 0, -1);
    check("startstop_y",    y_v,    64'h0);
    check("startstop_busy", busy_v, 64'h0);
    check("startstop_done", done_v, 64'h0);

    // reset during GAP (cycle 5): all low from cycle 6
    run_frame(8'b0000_0110, 4'd3, 1, 10, -1, -1, 5);
    check("midrst_y",    y_v,    64'h00C);
    check("midrst_busy", busy_v, 64'h03E);
    check("midrst_done", done_v, 64'h000);
    run_frame(8'b0000_0110, 4'd3, 1, 10, -1, -1, -1);
    check_basic("after_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
